// File: rtl/linebuf_writer.sv
// Sprite line-buffer writer: read-check-write per pixel with first-written-wins priority and a double-buffered bank swap.
// Optional collision counter is enabled with `define LINEBUF_COLLISION_EN.
module linebuf_writer #(
  parameter int XMAX = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        line_start,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic [8:0]  pix_x,
  input  logic [10:0] pix_dat,
  output logic [9:0]  lb_wadr,
  output logic [10:0] lb_wdat,
  output logic        lb_we,
  input  logic [10:0] lb_rdat1,
  output logic        rd_bank,
  input  logic        coll_clr,
  output logic        coll_flag,
  output logic [7:0]  coll_cnt,
  output logic [1:0]  dbg_state
);

  // Handshake: a pixel transfers on a clk edge where pix_valid & pix_ready are both high
  // and line_start is low; pix_x/pix_dat are captured at that edge.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    CHK  = 2'd2,
    WR   = 2'd3
  } state_t;

  localparam logic [10:0] XLIM = 11'(XMAX);

  state_t      state_q, state_d;
  logic        bank_q;
  logic        wr_ok_q;
  logic [9:0]  adr_q;
  logic [10:0] dat_q;
  logic        accept, discard, start_px, blocked;
  logic        unused_rdat;

  assign pix_ready = (state_q == IDLE) && rst_n;
  assign accept    = pix_valid && pix_ready && !line_start;
  assign discard   = (pix_dat[3:0] == 4'd0) || ({2'b00, pix_x} >= XLIM);
  assign start_px  = accept && !discard;
  assign blocked   = (state_q == CHK) && !line_start && (lb_rdat1[3:0] != 4'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_px) state_d = RD;
      RD:      state_d = line_start ? IDLE : CHK;
      CHK:     state_d = line_start ? IDLE : WR;
      WR:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bank_q  <= 1'b0;
      wr_ok_q <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
    end else begin
      if (line_start) bank_q <= ~bank_q;
      if (start_px) begin
        adr_q <= {bank_q, pix_x};
        dat_q <= pix_dat;
      end
      if (state_q == CHK) wr_ok_q <= (lb_rdat1[3:0] == 4'd0);
    end
  end

  // A line_start landing in WR still cancels the write in that same cycle.
  assign lb_we     = (state_q == WR) && wr_ok_q && !line_start;
  assign lb_wadr   = adr_q;
  assign lb_wdat   = dat_q;
  assign rd_bank   = ~bank_q;
  assign dbg_state = state_q;
  assign unused_rdat = ^lb_rdat1[10:4];

`ifdef LINEBUF_COLLISION_EN
  // A clear coinciding with a new collision leaves that collision recorded.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      coll_flag <= 1'b0;
      coll_cnt  <= 8'd0;
    end else if (coll_clr) begin
      coll_flag <= blocked;
      coll_cnt  <= blocked ? 8'd1 : 8'd0;
    end else if (blocked) begin
      coll_flag <= 1'b1;
      if (coll_cnt != 8'd255) coll_cnt <= coll_cnt + 8'd1;
    end
  end
`else
  logic unused_coll;
  assign unused_coll = coll_clr ^ blocked;
  assign coll_flag   = 1'b0;
  assign coll_cnt    = 8'd0;
`endif

endmodule
